// File: rtl/expand_conv_feeder.sv
// Feed controller for the expand stage: paces layer/kernel RAM reads, aligns their data
// through a fixed pipeline and raises the per-unit data valid flags.
module expand_conv_feeder #(
    parameter int LAYER_W  = 72,
    parameter int KER3_W   = 72,
    parameter int N_KER3   = 4,
    parameter int KER1_W   = 32,
    parameter int CNT_W    = 8,
    parameter int AF_LEVEL = 230,
    parameter int RPT_W    = 7,
    parameter int PIPE_DLY = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic [1:0]               mode_i,
    input  logic [RPT_W-1:0]         rpt_limit_i,
    input  logic [15:0]              layer_total_i,
    output logic                     layer_req_o,
    input  logic                     layer_ready_i,
    input  logic [LAYER_W-1:0]       layer_data_i,
    output logic                     ker3_req_o,
    input  logic                     ker3_ready_i,
    input  logic [N_KER3*KER3_W-1:0] ker3_data_i,
    output logic                     ker1_req_o,
    input  logic                     ker1_ready_i,
    input  logic [KER1_W-1:0]        ker1_data_i,
    input  logic [CNT_W-1:0]         fifo3_count_i,
    input  logic [CNT_W-1:0]         fifo1_count_i,
    output logic [LAYER_W-1:0]       layer_data_o,
    output logic [N_KER3*KER3_W-1:0] ker3_data_o,
    output logic [KER1_W-1:0]        ker1_data_o,
    output logic                     flag3_o,
    output logic                     flag1_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [15:0]              layer_count_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int FLG_DLY = PIPE_DLY + 1;
    localparam int DRN_W   = (PIPE_DLY < 1) ? 1 : $clog2(PIPE_DLY + 1);
    localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_LEVEL);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_DLY);

    logic [1:0]         state_q, state_d;
    logic               en3_q, en3_d, en1_q, en1_d;
    logic [RPT_W-1:0]   rpt_lim_q, rpt_lim_d, rpt_cnt_q, rpt_cnt_d;
    logic [15:0]        total_q, total_d, layer_count_q, layer_count_d;
    logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic               fifo_ok_q, fifo_ok_d;
    logic [FLG_DLY-1:0] flag3_sr_q, flag3_sr_d, flag1_sr_q, flag1_sr_d;

    logic [LAYER_W-1:0]       layer_pipe_q [PIPE_DLY];
    logic [LAYER_W-1:0]       layer_pipe_d [PIPE_DLY];
    logic [N_KER3*KER3_W-1:0] ker3_pipe_q  [PIPE_DLY];
    logic [N_KER3*KER3_W-1:0] ker3_pipe_d  [PIPE_DLY];
    logic [KER1_W-1:0]        ker1_pipe_q  [PIPE_DLY];
    logic [KER1_W-1:0]        ker1_pipe_d  [PIPE_DLY];

    logic beat, grp_last, layer_req;

    // A start cycle never issues reads: it only reloads the configuration.
    assign beat = (state_q == S_RUN) && !start_i && layer_ready_i
                  && (!en3_q || ker3_ready_i) && (!en1_q || ker1_ready_i) && fifo_ok_q;
    assign grp_last  = (rpt_cnt_q == (rpt_lim_q - RPT_W'(1)));
    assign layer_req = beat && grp_last;

    always_comb begin
        state_d       = state_q;
        en3_d         = en3_q;
        en1_d         = en1_q;
        rpt_lim_d     = rpt_lim_q;
        rpt_cnt_d     = rpt_cnt_q;
        total_d       = total_q;
        layer_count_d = layer_count_q;
        drain_cnt_d   = drain_cnt_q;
        flag3_sr_d    = {flag3_sr_q[FLG_DLY-2:0], beat && en3_q};
        flag1_sr_d    = {flag1_sr_q[FLG_DLY-2:0], beat && en1_q};

        case (state_q)
            S_RUN: begin
                if (beat) begin
                    rpt_cnt_d = grp_last ? '0 : rpt_cnt_q + RPT_W'(1);
                end
                if (layer_req && (layer_count_q != total_q)) begin
                    layer_count_d = layer_count_q + 16'd1;
                end
                if (layer_req && (layer_count_d == total_q)) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + DRN_W'(1);
                if (drain_cnt_q == DRN_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Restart/abort wins over everything, including flags still in flight.
        if (start_i) begin
            en3_d         = (mode_i != 2'b10);
            en1_d         = (mode_i != 2'b01);
            rpt_lim_d     = (rpt_limit_i == '0) ? RPT_W'(1) : rpt_limit_i;
            total_d       = layer_total_i;
            rpt_cnt_d     = '0;
            layer_count_d = '0;
            drain_cnt_d   = '0;
            flag3_sr_d    = '0;
            flag1_sr_d    = '0;
            state_d       = (layer_total_i != 16'd0) ? S_RUN : S_DONE;
        end

        // Uses the about-to-be-active enables so the first RUN cycle sees a valid verdict.
        fifo_ok_d = (!en3_d || (fifo3_count_i < AF_LVL)) && (!en1_d || (fifo1_count_i < AF_LVL));
    end

    always_comb begin
        layer_pipe_d[0] = layer_data_i;
        ker3_pipe_d[0]  = ker3_data_i;
        ker1_pipe_d[0]  = ker1_data_i;
        for (int i = 1; i < PIPE_DLY; i++) begin
            layer_pipe_d[i] = layer_pipe_q[i-1];
            ker3_pipe_d[i]  = ker3_pipe_q[i-1];
            ker1_pipe_d[i]  = ker1_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            en3_q         <= 1'b0;
            en1_q         <= 1'b0;
            rpt_lim_q     <= '0;
            rpt_cnt_q     <= '0;
            total_q       <= '0;
            layer_count_q <= '0;
            drain_cnt_q   <= '0;
            fifo_ok_q     <= 1'b0;
            flag3_sr_q    <= '0;
            flag1_sr_q    <= '0;
            for (int i = 0; i < PIPE_DLY; i++) begin
                layer_pipe_q[i] <= '0;
                ker3_pipe_q[i]  <= '0;
                ker1_pipe_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            en3_q         <= en3_d;
            en1_q         <= en1_d;
            rpt_lim_q     <= rpt_lim_d;
            rpt_cnt_q     <= rpt_cnt_d;
            total_q       <= total_d;
            layer_count_q <= layer_count_d;
            drain_cnt_q   <= drain_cnt_d;
            fifo_ok_q     <= fifo_ok_d;
            flag3_sr_q    <= flag3_sr_d;
            flag1_sr_q    <= flag1_sr_d;
            layer_pipe_q  <= layer_pipe_d;
            ker3_pipe_q   <= ker3_pipe_d;
            ker1_pipe_q   <= ker1_pipe_d;
        end
    end

    assign layer_req_o   = layer_req;
    assign ker3_req_o    = beat && en3_q;
    assign ker1_req_o    = beat && en1_q;
    assign layer_data_o  = layer_pipe_q[PIPE_DLY-1];
    assign ker3_data_o   = ker3_pipe_q[PIPE_DLY-1];
    assign ker1_data_o   = ker1_pipe_q[PIPE_DLY-1];
    assign flag3_o       = flag3_sr_q[FLG_DLY-1];
    assign flag1_o       = flag1_sr_q[FLG_DLY-1];
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign layer_count_o = layer_count_q;
endmodule

// File: tb/tb_expand_conv_feeder.sv
// Directed bench for expand_conv_feeder: per-cycle event logging, per-scenario inline checks.
module tb_expand_conv_feeder;
    localparam int LW = 72, KW = 72, NK = 4, K1W = 32, CW = 8, RW = 7, PD = 2;

    logic clk_i = 1'b0, rst_n_i = 1'b0, start_i = 1'b0;
    logic [1:0] mode_i = 2'b11;
    logic [RW-1:0] rpt_limit_i = '0;
    logic [15:0] layer_total_i = '0;
    logic layer_ready_i = 1'b1, ker3_ready_i = 1'b1, ker1_ready_i = 1'b1;
    logic [LW-1:0] layer_data_i;
    logic [NK*KW-1:0] ker3_data_i;
    logic [K1W-1:0] ker1_data_i;
    logic [CW-1:0] fifo3_count_i = '0, fifo1_count_i = '0;
    logic layer_req_o, ker3_req_o, ker1_req_o, flag3_o, flag1_o, busy_o, done_o;
    logic [LW-1:0] layer_data_o;
    logic [NK*KW-1:0] ker3_data_o;
    logic [K1W-1:0] ker1_data_o;
    logic [15:0] layer_count_o;

    expand_conv_feeder dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .mode_i(mode_i),
        .rpt_limit_i(rpt_limit_i), .layer_total_i(layer_total_i),
        .layer_req_o(layer_req_o), .layer_ready_i(layer_ready_i), .layer_data_i(layer_data_i),
        .ker3_req_o(ker3_req_o), .ker3_ready_i(ker3_ready_i), .ker3_data_i(ker3_data_i),
        .ker1_req_o(ker1_req_o), .ker1_ready_i(ker1_ready_i), .ker1_data_i(ker1_data_i),
        .fifo3_count_i(fifo3_count_i), .fifo1_count_i(fifo1_count_i),
        .layer_data_o(layer_data_o), .ker3_data_o(ker3_data_o), .ker1_data_o(ker1_data_o),
        .flag3_o(flag3_o), .flag1_o(flag1_o), .busy_o(busy_o), .done_o(done_o),
        .layer_count_o(layer_count_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    int beat_q[$], lreq_q[$], f3_q[$], f1_q[$], done_q[$];
    int k3req_n, orphan_n, data_err;

    function automatic logic [LW-1:0] tag_layer(input int c);
        logic [7:0] b;
        b = 8'(c);
        return {9{b}};
    endfunction

    function automatic logic [NK*KW-1:0] tag_k3(input int c);
        logic [NK*KW-1:0] v;
        logic [7:0] b;
        for (int k = 0; k < NK; k++) begin
            b = 8'(c) ^ (8'h35 + 8'(k));
            v[k*KW +: KW] = {9{b}};
        end
        return v;
    endfunction

    function automatic logic [K1W-1:0] tag_k1(input int c);
        logic [7:0] b;
        b = ~8'(c);
        return {4{b}};
    endfunction

    // Flag n must trail beat n by PD+1 cycles; returns the number of violations.
    function automatic int align_err(input bit use3);
        int e;
        int n;
        e = 0;
        n = use3 ? f3_q.size() : f1_q.size();
        if (n != beat_q.size()) return 1000;
        for (int i = 0; i < n; i++) begin
            if ((use3 ? f3_q[i] : f1_q[i]) != beat_q[i] + PD + 1) e++;
        end
        return e;
    endfunction

    task automatic clear_log();
        beat_q.delete(); lreq_q.delete(); f3_q.delete(); f1_q.delete(); done_q.delete();
        k3req_n = 0; orphan_n = 0; data_err = 0;
    endtask

    task automatic drive_tags();
        layer_data_i = tag_layer(cyc);
        ker3_data_i  = tag_k3(cyc);
        ker1_data_i  = tag_k1(cyc);
    endtask

    // Samples the current cycle late, logs events, then advances to just after the next edge.
    task automatic step();
        #2;
        if (ker3_req_o || ker1_req_o) begin
            beat_q.push_back(cyc);
            if (layer_req_o) lreq_q.push_back(beat_q.size() - 1);
        end else if (layer_req_o) begin
            orphan_n++;
        end
        if (ker3_req_o) k3req_n++;
        if (flag3_o) begin
            f3_q.push_back(cyc);
            if (ker3_data_o !== tag_k3(cyc - PD) || layer_data_o !== tag_layer(cyc - PD)) data_err++;
        end
        if (flag1_o) begin
            f1_q.push_back(cyc);
            if (ker1_data_o !== tag_k1(cyc - PD) || layer_data_o !== tag_layer(cyc - PD)) data_err++;
        end
        if (done_o) done_q.push_back(cyc);
        @(posedge clk_i);
        #1;
        cyc++;
        drive_tags();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_run(input logic [1:0] m, input logic [RW-1:0] r, input logic [15:0] t,
                             output int sc);
        mode_i = m; rpt_limit_i = r; layer_total_i = t; start_i = 1'b1; sc = cyc;
        step();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        drive_tags();
        steps(3);
        vectors++;
        if ({busy_o, done_o, flag3_o, flag1_o, layer_req_o, ker3_req_o, ker1_req_o} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {busy_o, done_o, flag3_o, flag1_o, layer_req_o, ker3_req_o, ker1_req_o});
        end
        vectors++;
        if (layer_count_o !== 16'd0 || layer_data_o !== '0 || ker3_data_o !== '0 || ker1_data_o !== '0) begin
            miscompares++;
            $display("FAIL reset_data: count %0d layer %h required all zero", layer_count_o, layer_data_o);
        end
        rst_n_i = 1'b1;
        steps(2);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int s, last;
        clear_log();
        start_run(2'b11, 7'd4, 16'd3, s);
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy: got %b required 1", busy_o);
        end
        steps(20);
        last = (beat_q.size() > 0) ? beat_q[beat_q.size()-1] : -1;
        vectors++;
        if (beat_q.size() != 12 || beat_q[0] != s + 1 || last != s + 12) begin
            miscompares++;
            $display("FAIL basic_beats: got %0d beats ending cycle %0d required 12 ending %0d",
                     beat_q.size(), last, s + 12);
        end
        vectors++;
        if (lreq_q.size() != 3 || lreq_q[0] != 3 || lreq_q[1] != 7 || lreq_q[2] != 11 || orphan_n != 0) begin
            miscompares++;
            $display("FAIL basic_layer_req: got %0d reqs (orphans %0d) required beats 3,7,11",
                     lreq_q.size(), orphan_n);
        end
        vectors++;
        if (align_err(1'b1) != 0 || align_err(1'b0) != 0) begin
            miscompares++;
            $display("FAIL basic_flags: got %0d/%0d misaligned required 0", align_err(1'b1), align_err(1'b0));
        end
        vectors++;
        if (data_err != 0) begin
            miscompares++;
            $display("FAIL basic_data: got %0d bad words required 0", data_err);
        end
        vectors++;
        if (done_q.size() != 1 || done_q[0] != last + PD + 2) begin
            miscompares++;
            $display("FAIL basic_done: got %0d pulses first %0d required 1 at %0d",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, last + PD + 2);
        end
        vectors++;
        if (layer_count_o !== 16'd3 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_end: got count %0d busy %b required 3 and 0", layer_count_o, busy_o);
        end
        $display("test_basic done: %0d beats", beat_q.size());
    endtask

    task automatic test_backpressure();
        int s, c, in_stall, resume;
        clear_log();
        start_run(2'b11, 7'd4, 16'd3, s);
        steps(4);
        c = cyc;
        fifo3_count_i = 8'd230;
        steps(6);
        fifo3_count_i = 8'd229;
        steps(22);
        fifo3_count_i = 8'd0;
        in_stall = 0;
        resume = -1;
        foreach (beat_q[i]) begin
            if (beat_q[i] >= c + 1 && beat_q[i] <= c + 6) in_stall++;
            if (beat_q[i] > c + 6 && resume < 0) resume = beat_q[i];
        end
        vectors++;
        if (in_stall != 0) begin
            miscompares++;
            $display("FAIL bp_stall: got %0d beats while full required 0", in_stall);
        end
        vectors++;
        if (resume != c + 7) begin
            miscompares++;
            $display("FAIL bp_resume: got cycle %0d required %0d", resume, c + 7);
        end
        vectors++;
        if (beat_q.size() != 12 || lreq_q.size() != 3 || done_q.size() != 1) begin
            miscompares++;
            $display("FAIL bp_totals: got beats %0d reqs %0d done %0d required 12 3 1",
                     beat_q.size(), lreq_q.size(), done_q.size());
        end
        vectors++;
        if (align_err(1'b1) != 0 || data_err != 0) begin
            miscompares++;
            $display("FAIL bp_flags: got %0d misaligned %0d bad data required 0 0", align_err(1'b1), data_err);
        end
        $display("test_backpressure done: resume at cycle %0d", resume);
    endtask

    task automatic test_mode_1x1();
        int s;
        clear_log();
        ker3_ready_i = 1'b0;
        fifo3_count_i = 8'd255;
        start_run(2'b10, 7'd4, 16'd3, s);
        steps(22);
        vectors++;
        if (k3req_n != 0 || f3_q.size() != 0) begin
            miscompares++;
            $display("FAIL m1_ker3: got %0d reqs %0d flags required 0 0", k3req_n, f3_q.size());
        end
        vectors++;
        if (beat_q.size() != 12 || align_err(1'b0) != 0 || data_err != 0) begin
            miscompares++;
            $display("FAIL m1_path1: got %0d beats %0d misaligned required 12 0", beat_q.size(), align_err(1'b0));
        end
        vectors++;
        if (done_q.size() != 1 || layer_count_o !== 16'd3) begin
            miscompares++;
            $display("FAIL m1_end: got done %0d count %0d required 1 3", done_q.size(), layer_count_o);
        end
        ker3_ready_i = 1'b1;
        fifo3_count_i = 8'd0;
        $display("test_mode_1x1 done");
    endtask

    task automatic test_rpt_one(input logic [RW-1:0] r);
        int s;
        clear_log();
        start_run(2'b11, r, 16'd5, s);
        steps(12);
        vectors++;
        if (beat_q.size() != 5 || lreq_q.size() != 5) begin
            miscompares++;
            $display("FAIL rpt%0d_reqs: got %0d beats %0d layer reqs required 5 5", r, beat_q.size(), lreq_q.size());
        end
        vectors++;
        if (layer_count_o !== 16'd5 || done_q.size() != 1) begin
            miscompares++;
            $display("FAIL rpt%0d_end: got count %0d done %0d required 5 1", r, layer_count_o, done_q.size());
        end
        $display("test_rpt_one done: rpt=%0d", r);
    endtask

    task automatic test_abort();
        int s, a, last;
        clear_log();
        start_run(2'b11, 7'd4, 16'd3, s);
        steps(6);
        vectors++;
        if (beat_q.size() != 6 || layer_count_o !== 16'd1) begin
            miscompares++;
            $display("FAIL abort_pre: got %0d beats count %0d required 6 1", beat_q.size(), layer_count_o);
        end
        start_run(2'b11, 7'd4, 16'd3, a);
        clear_log();
        vectors++;
        if (layer_count_o !== 16'd0) begin
            miscompares++;
            $display("FAIL abort_clear: got count %0d required 0", layer_count_o);
        end
        steps(20);
        last = (beat_q.size() > 0) ? beat_q[beat_q.size()-1] : -1;
        vectors++;
        if (beat_q.size() != 12 || beat_q[0] != a + 1 || lreq_q.size() != 3) begin
            miscompares++;
            $display("FAIL abort_beats: got %0d beats %0d reqs required 12 3", beat_q.size(), lreq_q.size());
        end
        vectors++;
        if (align_err(1'b1) != 0 || align_err(1'b0) != 0) begin
            miscompares++;
            $display("FAIL abort_flags: got %0d flag3 for %0d beats required none stale", f3_q.size(), beat_q.size());
        end
        vectors++;
        if (done_q.size() != 1 || done_q[0] != last + PD + 2) begin
            miscompares++;
            $display("FAIL abort_done: got %0d pulses required 1 at %0d", done_q.size(), last + PD + 2);
        end
        $display("test_abort done");
    endtask

    task automatic test_async_reset_and_zero();
        int s;
        clear_log();
        start_run(2'b11, 7'd1, 16'd1, s);
        steps(3);
        #2;
        vectors++;
        if (flag3_o !== 1'b1 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre: got flag3 %b busy %b required 1 1", flag3_o, busy_o);
        end
        rst_n_i = 1'b0;
        #1;
        vectors++;
        if ({busy_o, done_o, flag3_o, flag1_o} !== 4'd0 || layer_count_o !== 16'd0) begin
            miscompares++;
            $display("FAIL rst_async_ctrl: got %b count %0d required 0000 0",
                     {busy_o, done_o, flag3_o, flag1_o}, layer_count_o);
        end
        vectors++;
        if (layer_data_o !== '0 || ker3_data_o !== '0 || ker1_data_o !== '0) begin
            miscompares++;
            $display("FAIL rst_async_data: got layer %h required 0", layer_data_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        cyc++;
        drive_tags();
        clear_log();
        start_run(2'b11, 7'd4, 16'd0, s);
        steps(5);
        vectors++;
        if (done_q.size() != 1 || done_q[0] != s + 1) begin
            miscompares++;
            $display("FAIL zero_done: got %0d pulses first %0d required 1 at %0d",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, s + 1);
        end
        vectors++;
        if (beat_q.size() != 0 || orphan_n != 0 || layer_count_o !== 16'd0) begin
            miscompares++;
            $display("FAIL zero_reqs: got %0d beats %0d layer reqs required 0 0", beat_q.size(), orphan_n);
        end
        $display("test_async_reset_and_zero done");
    endtask

    initial begin
        clear_log();
        test_reset();
        test_basic();
        test_backpressure();
        test_mode_1x1();
        test_rpt_one(7'd1);
        test_rpt_one(7'd0);
        test_abort();
        test_async_reset_and_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
